hermes_egress_framer: RTL and testbench



---
 rtl/hermes_egress_framer_if.sv | 33 +++
 rtl/hermes_egress_framer.sv | 124 ++++++++++++
 tb/tb_hermes_egress_framer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hermes_egress_framer_if.sv
`default_nettype none
// hermes_egress_framer_if: DMNI-side and router-side flit handshakes plus packet monitor outputs.
// Rev 1.0
interface hermes_egress_framer_if #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
);
  localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;

  logic                 dmni_tx_i;
  logic                 dmni_credit_o;
  logic [FLIT_SIZE-1:0] dmni_data_i;
  logic                 noc_tx_o;
  logic                 noc_credit_i;
  logic [FLIT_SIZE-1:0] noc_data_o;
  logic [CNT_W-1:0]     flits_stored_o;
  logic [CNT_W-1:0]     pkts_buffered_o;
  logic                 pkt_in_done_o;
  logic                 pkt_out_done_o;

  modport slave (
    input  dmni_tx_i, dmni_data_i, noc_credit_i,
    output dmni_credit_o, noc_tx_o, noc_data_o,
           flits_stored_o, pkts_buffered_o, pkt_in_done_o, pkt_out_done_o
  );

  modport master (
    output dmni_tx_i, dmni_data_i, noc_credit_i,
    input  dmni_credit_o, noc_tx_o, noc_data_o,
           flits_stored_o, pkts_buffered_o, pkt_in_done_o, pkt_out_done_o
  );
endinterface
`default_nettype wire

// File: rtl/hermes_egress_framer.sv
`default_nettype none
// hermes_egress_framer: circular flit FIFO between DMNI and router with Hermes framing trackers.
// Rev 1.0
module hermes_egress_framer #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  hermes_egress_framer_if.slave bus
);
  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    SIZE = 2'd1,
    PAY  = 2'd2
  } frame_state_t;

  logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     pkts;
  frame_state_t         in_state;
  frame_state_t         out_state;
  logic [FLIT_SIZE-1:0] rem_in;
  logic [FLIT_SIZE-1:0] rem_out;
  logic                 in_done;
  logic                 out_done;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic in_complete;
  logic out_complete;

  assign full  = (count == CNT_W'(BUFFER_SIZE));
  assign empty = (count == '0);
  assign push  = bus.dmni_tx_i & ~full;
  assign pop   = ~empty & bus.noc_credit_i;

  // A size flit of zero closes the packet immediately; otherwise the last payload flit does.
  assign in_complete  = push & (((in_state == SIZE) && (bus.dmni_data_i == '0)) ||
                                ((in_state == PAY)  && (rem_in == FLIT_SIZE'(1))));
  assign out_complete = pop  & (((out_state == SIZE) && (bus.noc_data_o == '0)) ||
                                ((out_state == PAY)  && (rem_out == FLIT_SIZE'(1))));

  assign bus.dmni_credit_o   = ~full;
  assign bus.noc_tx_o        = ~empty;
  assign bus.noc_data_o      = mem[rd_ptr];
  assign bus.flits_stored_o  = count;
  assign bus.pkts_buffered_o = pkts;
  assign bus.pkt_in_done_o   = in_done;
  assign bus.pkt_out_done_o  = out_done;

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= bus.dmni_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkts      <= '0;
      in_state  <= HDR;
      out_state <= HDR;
      rem_in    <= '0;
      rem_out   <= '0;
      in_done   <= 1'b0;
      out_done  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      in_done  <= in_complete;
      out_done <= out_complete;

      case ({in_complete, out_complete})
        2'b10:   pkts <= pkts + CNT_W'(1);
        2'b01:   pkts <= pkts - CNT_W'(1);
        default: pkts <= pkts;
      endcase

      case (in_state)
        HDR: if (push) in_state <= SIZE;
        SIZE: if (push) begin
          rem_in   <= bus.dmni_data_i;
          in_state <= (bus.dmni_data_i == '0) ? HDR : PAY;
        end
        PAY: if (push) begin
          rem_in <= rem_in - FLIT_SIZE'(1);
          if (rem_in == FLIT_SIZE'(1)) in_state <= HDR;
        end
        default: in_state <= HDR;
      endcase

      case (out_state)
        HDR: if (pop) out_state <= SIZE;
        SIZE: if (pop) begin
          rem_out   <= bus.noc_data_o;
          out_state <= (bus.noc_data_o == '0) ? HDR : PAY;
        end
        PAY: if (pop) begin
          rem_out <= rem_out - FLIT_SIZE'(1);
          if (rem_out == FLIT_SIZE'(1)) out_state <= HDR;
        end
        default: out_state <= HDR;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_hermes_egress_framer.sv
`default_nettype none
// tb_hermes_egress_framer: scoreboard bench for the egress framer FIFO and packet counters.
// Rev 1.0
module tb_hermes_egress_framer;
  localparam int FS = 32;
  localparam int BS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hermes_egress_framer_if #(.FLIT_SIZE(FS), .BUFFER_SIZE(BS)) bus ();

  hermes_egress_framer #(.FLIT_SIZE(FS), .BUFFER_SIZE(BS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [FS-1:0] exp_q[$];
  int in_done_cnt  = 0;
  int out_done_cnt = 0;
  int pop_cnt      = 0;
  int max_pkts     = 0;

  // Output-side scoreboard: a flit is consumed on the coming edge when tx and credit are both high.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pkt_in_done_o)  in_done_cnt++;
      if (bus.pkt_out_done_o) out_done_cnt++;
      if (int'(bus.pkts_buffered_o) > max_pkts) max_pkts = int'(bus.pkts_buffered_o);
      if (bus.noc_tx_o && bus.noc_credit_i) begin
        logic [FS-1:0] e;
        checks++;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected got=%h expected=none", bus.noc_data_o);
        end else begin
          e = exp_q.pop_front();
          if (bus.noc_data_o !== e) begin
            failures++;
            $display("FAIL pop_data got=%h expected=%h", bus.noc_data_o, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    in_done_cnt  = 0;
    out_done_cnt = 0;
    pop_cnt      = 0;
    max_pkts     = 0;
  endtask

  task automatic send_flit(input logic [FS-1:0] d);
    int n;
    bus.dmni_tx_i   = 1'b1;
    bus.dmni_data_i = d;
    n = 0;
    while (!bus.dmni_credit_o && n < 200) begin
      tick();
      n++;
    end
    if (!bus.dmni_credit_o) begin
      checks++;
      failures++;
      $display("FAIL send_timeout credit=%b expected=1", bus.dmni_credit_o);
    end else begin
      exp_q.push_back(d);
    end
    tick();
    bus.dmni_tx_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.noc_credit_i = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.noc_tx_o) && n < 200) begin
      tick();
      n++;
    end
    bus.noc_credit_i = 1'b0;
    checks++;
    if (bus.noc_tx_o !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout noc_tx=%b left=%0d expected=0", bus.noc_tx_o, exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.dmni_tx_i    = 1'b0;
    bus.dmni_data_i  = '0;
    bus.noc_credit_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks += 6;
    if (bus.noc_tx_o !== 1'b0) begin failures++; $display("FAIL rst_noc_tx got=%b expected=0", bus.noc_tx_o); end
    if (bus.dmni_credit_o !== 1'b1) begin failures++; $display("FAIL rst_credit got=%b expected=1", bus.dmni_credit_o); end
    if (bus.flits_stored_o !== '0) begin failures++; $display("FAIL rst_flits got=%0d expected=0", bus.flits_stored_o); end
    if (bus.pkts_buffered_o !== '0) begin failures++; $display("FAIL rst_pkts got=%0d expected=0", bus.pkts_buffered_o); end
    if (bus.pkt_in_done_o !== 1'b0) begin failures++; $display("FAIL rst_in_done got=%b expected=0", bus.pkt_in_done_o); end
    if (bus.pkt_out_done_o !== 1'b0) begin failures++; $display("FAIL rst_out_done got=%b expected=0", bus.pkt_out_done_o); end
  endtask

  task automatic test_single_packet();
    clear_counts();
    bus.noc_credit_i = 1'b0;
    send_flit(32'h0101);
    send_flit(32'd3);
    send_flit(32'hA);
    send_flit(32'hB);
    checks++;
    if (bus.pkt_in_done_o !== 1'b0) begin failures++; $display("FAIL single_in_done_early got=%b expected=0", bus.pkt_in_done_o); end
    send_flit(32'hC);
    checks += 4;
    if (bus.flits_stored_o !== 5) begin failures++; $display("FAIL single_flits got=%0d expected=5", bus.flits_stored_o); end
    if (bus.pkt_in_done_o !== 1'b1) begin failures++; $display("FAIL single_in_done got=%b expected=1", bus.pkt_in_done_o); end
    if (bus.pkts_buffered_o !== 1) begin failures++; $display("FAIL single_pkts got=%0d expected=1", bus.pkts_buffered_o); end
    if (bus.noc_tx_o !== 1'b1) begin failures++; $display("FAIL single_noc_tx got=%b expected=1", bus.noc_tx_o); end
    tick();
    checks++;
    if (bus.pkt_in_done_o !== 1'b0) begin failures++; $display("FAIL single_in_pulse_width got=%b expected=0", bus.pkt_in_done_o); end
    drain();
    checks += 5;
    if (pop_cnt != 5) begin failures++; $display("FAIL single_pops got=%0d expected=5", pop_cnt); end
    if (in_done_cnt != 1) begin failures++; $display("FAIL single_in_pulses got=%0d expected=1", in_done_cnt); end
    if (out_done_cnt != 1) begin failures++; $display("FAIL single_out_pulses got=%0d expected=1", out_done_cnt); end
    if (bus.pkts_buffered_o !== 0) begin failures++; $display("FAIL single_pkts_end got=%0d expected=0", bus.pkts_buffered_o); end
    if (bus.flits_stored_o !== 0) begin failures++; $display("FAIL single_flits_end got=%0d expected=0", bus.flits_stored_o); end
  endtask

  task automatic test_full();
    clear_counts();
    bus.noc_credit_i = 1'b0;
    send_flit(32'h0202);
    send_flit(32'd6);
    for (int i = 0; i < 6; i++) send_flit(32'h100 + i);
    checks += 3;
    if (bus.flits_stored_o !== 8) begin failures++; $display("FAIL full_flits got=%0d expected=8", bus.flits_stored_o); end
    if (bus.dmni_credit_o !== 1'b0) begin failures++; $display("FAIL full_credit got=%b expected=0", bus.dmni_credit_o); end
    if (bus.pkts_buffered_o !== 1) begin failures++; $display("FAIL full_pkts got=%0d expected=1", bus.pkts_buffered_o); end
    bus.dmni_tx_i   = 1'b1;
    bus.dmni_data_i = 32'hDEAD;
    tick();
    bus.dmni_tx_i = 1'b0;
    checks++;
    if (bus.flits_stored_o !== 8) begin failures++; $display("FAIL full_no_push got=%0d expected=8", bus.flits_stored_o); end
    bus.noc_credit_i = 1'b1;
    tick();
    bus.noc_credit_i = 1'b0;
    checks += 2;
    if (bus.dmni_credit_o !== 1'b1) begin failures++; $display("FAIL full_credit_back got=%b expected=1", bus.dmni_credit_o); end
    if (bus.flits_stored_o !== 7) begin failures++; $display("FAIL full_after_pop got=%0d expected=7", bus.flits_stored_o); end
    bus.noc_credit_i = 1'b1;
    repeat (3) tick();
    bus.noc_credit_i = 1'b0;
    checks++;
    if (bus.flits_stored_o !== 4) begin failures++; $display("FAIL full_occ4 got=%0d expected=4", bus.flits_stored_o); end
    bus.dmni_tx_i    = 1'b1;
    bus.dmni_data_i  = 32'h0303;
    bus.noc_credit_i = 1'b1;
    exp_q.push_back(32'h0303);
    tick();
    bus.dmni_tx_i    = 1'b0;
    bus.noc_credit_i = 1'b0;
    checks++;
    if (bus.flits_stored_o !== 4) begin failures++; $display("FAIL full_push_pop got=%0d expected=4", bus.flits_stored_o); end
    send_flit(32'd0);
    drain();
    checks += 3;
    if (pop_cnt != 10) begin failures++; $display("FAIL full_pops got=%0d expected=10", pop_cnt); end
    if (out_done_cnt != 2) begin failures++; $display("FAIL full_out_pulses got=%0d expected=2", out_done_cnt); end
    if (bus.pkts_buffered_o !== 0) begin failures++; $display("FAIL full_pkts_end got=%0d expected=0", bus.pkts_buffered_o); end
  endtask

  task automatic test_back_to_back_zero();
    int seen[$];
    int last;
    clear_counts();
    bus.noc_credit_i = 1'b0;
    send_flit(32'hE1);
    send_flit(32'd0);
    send_flit(32'hE2);
    send_flit(32'd0);
    tick();
    checks += 2;
    if (bus.pkts_buffered_o !== 2) begin failures++; $display("FAIL zero_pkts got=%0d expected=2", bus.pkts_buffered_o); end
    if (in_done_cnt != 2) begin failures++; $display("FAIL zero_in_pulses got=%0d expected=2", in_done_cnt); end
    last = int'(bus.pkts_buffered_o);
    bus.noc_credit_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (int'(bus.pkts_buffered_o) != last) begin
        last = int'(bus.pkts_buffered_o);
        seen.push_back(last);
      end
    end
    bus.noc_credit_i = 1'b0;
    checks++;
    if (seen.size() != 2 || seen[0] != 1 || seen[1] != 0) begin
      failures++;
      $display("FAIL zero_drain_seq changes=%0d got_last=%0d expected=1,0", seen.size(), last);
    end
    checks += 2;
    if (out_done_cnt != 2) begin failures++; $display("FAIL zero_out_pulses got=%0d expected=2", out_done_cnt); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL zero_left got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_long_stream();
    bit sent = 1'b0;
    int n = 0;
    clear_counts();
    fork
      begin
        send_flit(32'h0404);
        send_flit(32'd20);
        for (int i = 0; i < 20; i++) send_flit(32'h5000 + i);
        sent = 1'b1;
      end
      begin
        while (!(sent && exp_q.size() == 0 && !bus.noc_tx_o) && n < 3000) begin
          bus.noc_credit_i = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        bus.noc_credit_i = 1'b0;
      end
    join
    tick();
    tick();
    checks += 5;
    if (n >= 3000) begin failures++; $display("FAIL long_timeout cycles=%0d expected<3000", n); end
    if (pop_cnt != 22) begin failures++; $display("FAIL long_pops got=%0d expected=22", pop_cnt); end
    if (out_done_cnt != 1) begin failures++; $display("FAIL long_out_pulses got=%0d expected=1", out_done_cnt); end
    if (max_pkts > 1) begin failures++; $display("FAIL long_max_pkts got=%0d expected<=1", max_pkts); end
    if (bus.pkts_buffered_o !== 0) begin failures++; $display("FAIL long_pkts_end got=%0d expected=0", bus.pkts_buffered_o); end
  endtask

  task automatic test_reset_mid_packet();
    bus.noc_credit_i = 1'b0;
    send_flit(32'h0606);
    send_flit(32'd5);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    clear_counts();
    checks++;
    if (bus.flits_stored_o !== 0) begin failures++; $display("FAIL midrst_flits got=%0d expected=0", bus.flits_stored_o); end
    send_flit(32'h0707);
    send_flit(32'd1);
    send_flit(32'h0888);
    drain();
    checks += 3;
    if (pop_cnt != 3) begin failures++; $display("FAIL midrst_pops got=%0d expected=3", pop_cnt); end
    if (out_done_cnt != 1) begin failures++; $display("FAIL midrst_out_pulses got=%0d expected=1", out_done_cnt); end
    if (bus.pkts_buffered_o !== 0) begin failures++; $display("FAIL midrst_pkts got=%0d expected=0", bus.pkts_buffered_o); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_full();
    test_back_to_back_zero();
    test_long_stream();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
